// File: rtl/pipeline_pkg.sv
// Shared definitions for the forwarding pipeline: opcode encodings and
// instruction field offsets for the {op, dst, src1, src2} layout.
package pipeline_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_PADD = 2'b10,
    OP_XOR  = 2'b11
  } op_e;

  localparam int OP_W = 2;

  function automatic int inst_len(input int addr_len);
    return OP_W + 3 * addr_len;
  endfunction

  // Field LSB positions; op occupies the MSBs above the three register fields.
  function automatic int op_lsb(input int addr_len);
    return 3 * addr_len;
  endfunction

  function automatic int dst_lsb(input int addr_len);
    return 2 * addr_len;
  endfunction

  function automatic int src1_lsb(input int addr_len);
    return addr_len;
  endfunction

  function automatic int src2_lsb(input int addr_len);
    return 0 * addr_len;
  endfunction

endpackage

// File: rtl/lane_alu.sv
// Combinational ALU: full-width ADD/SUB/XOR plus a partitioned add whose
// carries stop at every PART_LEN lane boundary.
module lane_alu
  import pipeline_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int PART_LEN  = 16
) (
  input  op_e                  op,
  input  logic [WORD_SIZE-1:0] a,
  input  logic [WORD_SIZE-1:0] b,
  output logic [WORD_SIZE-1:0] res
);

  localparam int NUM_LANES = WORD_SIZE / PART_LEN;

  logic [WORD_SIZE-1:0] padd_s;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign padd_s[g*PART_LEN +: PART_LEN] = a[g*PART_LEN +: PART_LEN] + b[g*PART_LEN +: PART_LEN];
  end

  // Result select by opcode
  always_comb begin
    res = '0;
    case (op)
      OP_ADD:  res = a + b;
      OP_SUB:  res = a - b;
      OP_PADD: res = padd_s;
      OP_XOR:  res = a ^ b;
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/pipeline_fwd_core.sv
// DEC/RD/EX/WB integer pipeline with full operand forwarding, a streamed
// instruction input and a back-pressurable retire port.
module pipeline_fwd_core
  import pipeline_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int ADDR_LEN  = 5,
  parameter int PART_LEN  = 16,
  parameter int ZERO_REG  = 1,
  parameter int INST_LEN  = 2 + 3 * ADDR_LEN
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_valid,
  output logic                 inst_ready,
  input  logic [INST_LEN-1:0]  inst,
  output logic                 wb_valid,
  input  logic                 wb_ready,
  output logic [ADDR_LEN-1:0]  wb_addr,
  output logic [WORD_SIZE-1:0] wb_data,
  input  logic [ADDR_LEN-1:0]  dbg_addr,
  output logic [WORD_SIZE-1:0] dbg_data
);

  localparam int NUM_REGS = 2 ** ADDR_LEN;
  localparam int OP_LSB   = op_lsb(ADDR_LEN);
  localparam int DST_LSB  = dst_lsb(ADDR_LEN);
  localparam int S1_LSB   = src1_lsb(ADDR_LEN);
  localparam int S2_LSB   = src2_lsb(ADDR_LEN);
  localparam bit ZR       = (ZERO_REG != 0);

  logic                 dec_valid_q, dec_valid_d;
  logic [INST_LEN-1:0]  dec_inst_q, dec_inst_d;
  logic                 rd_valid_q, rd_valid_d;
  op_e                  rd_op_q, rd_op_d;
  logic [ADDR_LEN-1:0]  rd_dst_q, rd_dst_d;
  logic [WORD_SIZE-1:0] rd_a_q, rd_a_d, rd_b_q, rd_b_d;
  logic                 wb_valid_q, wb_valid_d;
  logic [ADDR_LEN-1:0]  wb_addr_q, wb_addr_d;
  logic [WORD_SIZE-1:0] wb_data_q, wb_data_d;
  logic [WORD_SIZE-1:0] rf_q [NUM_REGS];

  logic                 stall_s, accept_s, commit_s;
  op_e                  dec_op_s;
  logic [ADDR_LEN-1:0]  dec_dst_s, dec_src1_s, dec_src2_s;
  logic [WORD_SIZE-1:0] opa_s, opb_s, alu_res_s;

  assign stall_s    = wb_valid_q & ~wb_ready;
  assign inst_ready = ~stall_s;
  assign accept_s   = inst_valid & inst_ready;
  assign commit_s   = wb_valid_q & wb_ready & ~(ZR & (wb_addr_q == '0));

  assign dec_op_s   = op_e'(dec_inst_q[OP_LSB +: OP_W]);
  assign dec_dst_s  = dec_inst_q[DST_LSB +: ADDR_LEN];
  assign dec_src1_s = dec_inst_q[S1_LSB +: ADDR_LEN];
  assign dec_src2_s = dec_inst_q[S2_LSB +: ADDR_LEN];

  lane_alu #(
    .WORD_SIZE (WORD_SIZE),
    .PART_LEN  (PART_LEN)
  ) u_alu (
    .op  (rd_op_q),
    .a   (rd_a_q),
    .b   (rd_b_q),
    .res (alu_res_s)
  );

  // Source-1 resolution: the younger in-flight writer (RD) wins over WB and the RF
  always_comb begin
    opa_s = rf_q[dec_src1_s];
    if (ZR && dec_src1_s == '0) begin
      opa_s = '0;
    end else if (rd_valid_q && rd_dst_q == dec_src1_s) begin
      opa_s = alu_res_s;
    end else if (wb_valid_q && wb_addr_q == dec_src1_s) begin
      opa_s = wb_data_q;
    end else begin
      opa_s = rf_q[dec_src1_s];
    end
  end

  // Source-2 resolution, same priority as source 1
  always_comb begin
    opb_s = rf_q[dec_src2_s];
    if (ZR && dec_src2_s == '0) begin
      opb_s = '0;
    end else if (rd_valid_q && rd_dst_q == dec_src2_s) begin
      opb_s = alu_res_s;
    end else if (wb_valid_q && wb_addr_q == dec_src2_s) begin
      opb_s = wb_data_q;
    end else begin
      opb_s = rf_q[dec_src2_s];
    end
  end

  // Stage advance; a retire stall freezes every stage at once
  always_comb begin
    dec_valid_d = dec_valid_q;
    dec_inst_d  = dec_inst_q;
    rd_valid_d  = rd_valid_q;
    rd_op_d     = rd_op_q;
    rd_dst_d    = rd_dst_q;
    rd_a_d      = rd_a_q;
    rd_b_d      = rd_b_q;
    wb_valid_d  = wb_valid_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    if (!stall_s) begin
      dec_valid_d = accept_s;
      if (accept_s) begin
        dec_inst_d = inst;
      end else begin
        dec_inst_d = dec_inst_q;
      end
      rd_valid_d = dec_valid_q;
      if (dec_valid_q) begin
        rd_op_d  = dec_op_s;
        rd_dst_d = dec_dst_s;
        rd_a_d   = opa_s;
        rd_b_d   = opb_s;
      end else begin
        rd_op_d  = rd_op_q;
      end
      wb_valid_d = rd_valid_q;
      if (rd_valid_q) begin
        wb_addr_d = rd_dst_q;
        wb_data_d = alu_res_s;
      end else begin
        wb_addr_d = wb_addr_q;
      end
    end else begin
      dec_valid_d = dec_valid_q;
    end
  end

  // Stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_q <= 1'b0;
      dec_inst_q  <= '0;
      rd_valid_q  <= 1'b0;
      rd_op_q     <= OP_ADD;
      rd_dst_q    <= '0;
      rd_a_q      <= '0;
      rd_b_q      <= '0;
      wb_valid_q  <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
    end else begin
      dec_valid_q <= dec_valid_d;
      dec_inst_q  <= dec_inst_d;
      rd_valid_q  <= rd_valid_d;
      rd_op_q     <= rd_op_d;
      rd_dst_q    <= rd_dst_d;
      rd_a_q      <= rd_a_d;
      rd_b_q      <= rd_b_d;
      wb_valid_q  <= wb_valid_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
    end
  end

  // Register file; reset has priority so a flushed result never commits
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (commit_s) begin
      rf_q[wb_addr_q] <= wb_data_q;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;
  assign dbg_data = rf_q[dbg_addr];

endmodule

// File: tb/tb_pipeline_fwd_core.sv
// Scoreboard bench: an architectural register model predicts every retired
// result at issue time; a monitor pops and compares on each wb handshake.
module tb_pipeline_fwd_core;

  localparam int W  = 32;
  localparam int A  = 5;
  localparam int IL = 2 + 3 * A;

  typedef struct {
    logic [A-1:0] addr;
    logic [W-1:0] data;
    int           cyc;
  } exp_t;

  logic          clk, rst, inst_valid, inst_ready, wb_valid, wb_ready;
  logic [IL-1:0] inst;
  logic [A-1:0]  wb_addr, dbg_addr;
  logic [W-1:0]  wb_data, dbg_data;

  logic          z_inst_valid, z_inst_ready, z_wb_valid, z_wb_ready;
  logic [IL-1:0] z_inst;
  logic [A-1:0]  z_wb_addr, z_dbg_addr;
  logic [W-1:0]  z_wb_data, z_dbg_data;

  pipeline_fwd_core #(.WORD_SIZE(W), .ADDR_LEN(A), .PART_LEN(16), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  pipeline_fwd_core #(.WORD_SIZE(W), .ADDR_LEN(A), .PART_LEN(16), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst(rst), .inst_valid(z_inst_valid), .inst_ready(z_inst_ready), .inst(z_inst),
    .wb_valid(z_wb_valid), .wb_ready(z_wb_ready), .wb_addr(z_wb_addr), .wb_data(z_wb_data),
    .dbg_addr(z_dbg_addr), .dbg_data(z_dbg_data)
  );

  int     n_chk = 0;
  int     n_pass = 0;
  int     cyc = 0;
  int     bp_mode = 0;
  bit     chk_lat = 1'b0;
  exp_t   exp_q[$];
  logic [W-1:0] model_rf [32];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [IL-1:0] enc(input logic [1:0] op, input int d, input int s1, input int s2);
    return {op, 5'(d), 5'(s1), 5'(s2)};
  endfunction

  function automatic logic [W-1:0] mread(input int r);
    if (r == 0) return 32'd0;
    return model_rf[r];
  endfunction

  // Architectural semantics: each instruction sees all older results.
  task automatic model_issue(input logic [IL-1:0] ins);
    logic [1:0]   op;
    int           d;
    logic [W-1:0] a, b, r;
    op = ins[16:15];
    d  = int'(ins[14:10]);
    a  = mread(int'(ins[9:5]));
    b  = mread(int'(ins[4:0]));
    case (op)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: for (int l = 0; l < W / 16; l++) r[l*16 +: 16] = a[l*16 +: 16] + b[l*16 +: 16];
      default: r = a ^ b;
    endcase
    if (d != 0) model_rf[d] = r;
    exp_q.push_back('{addr: 5'(d), data: r, cyc: cyc});
  endtask

  task automatic step(input bit v, input logic [IL-1:0] ins, output bit acc);
    @(negedge clk);
    inst_valid = v;
    inst       = ins;
    case (bp_mode)
      0: wb_ready = 1'b1;
      1: wb_ready = ($urandom_range(3) != 0);
      default: wb_ready = 1'b0;
    endcase
    #1;
    acc = v && inst_ready;
    if (acc) model_issue(ins);
  endtask

  task automatic issue(input logic [IL-1:0] ins);
    bit acc = 1'b0;
    for (int k = 0; k < 64 && !acc; k++) step(1'b1, ins, acc);
    chk("issue_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    bp_mode = 0;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step(1'b0, '0, acc);
    step(1'b0, '0, acc);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_rf(input string tag);
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      dbg_addr = 5'(r);
      #1;
      chk(tag, dbg_data, model_rf[r]);
    end
  endtask

  // The ISA has no immediate form, so nonzero seeds go straight into the array.
  task automatic preload(input int r, input logic [W-1:0] v);
    if (r != 0) begin
      dut.rf_q[r] = v;
      model_rf[r] = v;
    end
  endtask

  // Retire-port monitor: scoreboard pop, hold-while-stalled and ready checks
  logic         prev_stall = 1'b0;
  logic [A-1:0] prev_addr;
  logic [W-1:0] prev_data;
  exp_t         e;
  always begin
    @(negedge clk);
    #2;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(wb_valid), 32'd1);
        chk("hold_addr", 32'(wb_addr), 32'(prev_addr));
        chk("hold_data", wb_data, prev_data);
      end
      chk("inst_ready", 32'(inst_ready), 32'(!(wb_valid && !wb_ready)));
      if (wb_valid && wb_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wb", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("wb_addr", 32'(wb_addr), 32'(e.addr));
          chk("wb_data", wb_data, e.data);
          if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'd3);
        end
      end
      prev_stall = wb_valid && !wb_ready;
      prev_addr  = wb_addr;
      prev_data  = wb_data;
    end
  end

  initial begin
    bit acc;
    logic [W-1:0] z_res [2];
    int nz;
    clk = 1'b0; rst = 1'b1; inst_valid = 1'b0; inst = '0; wb_ready = 1'b1; dbg_addr = '0;
    z_inst_valid = 1'b0; z_inst = '0; z_wb_ready = 1'b1; z_dbg_addr = '0;
    for (int r = 0; r < 32; r++) model_rf[r] = '0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_inst_ready", 32'(inst_ready), 32'd1);
    chk("rst_wb_addr", 32'(wb_addr), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    check_rf("rst_rf");

    // r0 as an ordinary register: r0=2v, then r2=r0+r0=4v
    @(negedge clk);
    dut0.rf_q[1] = 32'd3;
    z_inst_valid = 1'b1; z_inst = enc(2'd0, 0, 1, 1);
    @(negedge clk);
    z_inst = enc(2'd0, 2, 0, 0);
    @(negedge clk);
    z_inst_valid = 1'b0;
    nz = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      if (z_wb_valid && nz < 2) begin z_res[nz] = z_wb_data; nz++; end
    end
    chk("z0_count", 32'(nz), 32'd2);
    chk("z0_r0", z_res[0], 32'd6);
    chk("z0_r2", z_res[1], 32'd12);
    z_dbg_addr = 5'd2; #1;
    chk("z0_dbg_r2", z_dbg_data, 32'd12);

    // Dependent chain with fixed latency
    preload(1, 32'd5);
    preload(2, 32'd7);
    chk_lat = 1'b1;
    issue(enc(2'd0, 3, 1, 2));
    issue(enc(2'd1, 4, 3, 1));
    issue(enc(2'd3, 5, 4, 3));
    drain();
    chk_lat = 1'b0;
    chk("chain_r5", model_rf[5], 32'd11);

    // Lane-partitioned add vs full add
    preload(1, 32'h0001FFFF);
    preload(2, 32'h00010001);
    issue(enc(2'd2, 3, 1, 2));
    issue(enc(2'd0, 4, 1, 2));
    drain();
    chk("padd_model", model_rf[3], 32'h00020000);
    check_rf("padd_rf");

    // Hard-wired zero register
    preload(1, 32'h12345678);
    issue(enc(2'd0, 0, 1, 1));
    issue(enc(2'd0, 2, 0, 0));
    drain();
    check_rf("zr_rf");

    // Back-pressure mid-stream
    for (int k = 0; k < 6; k++) issue(enc(2'($urandom_range(3)), $urandom_range(1, 7), $urandom_range(7), $urandom_range(7)));
    bp_mode = 2;
    for (int k = 0; k < 4; k++) step(1'b1, enc(2'd0, 6, 6, 1), acc);
    bp_mode = 0;
    for (int k = 0; k < 4; k++) issue(enc(2'($urandom_range(3)), $urandom_range(1, 7), $urandom_range(7), $urandom_range(7)));
    drain();
    check_rf("bp_rf");

    // Random traffic with random back-pressure and bubbles
    for (int r = 1; r < 32; r++) preload(r, $urandom);
    bp_mode = 1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(4) != 0) issue(enc(2'($urandom_range(3)), $urandom_range(7), $urandom_range(7), $urandom_range(7)));
      else step(1'b0, '0, acc);
    end
    drain();
    check_rf("rand_rf");

    // Reset with three instructions in flight
    issue(enc(2'd0, 1, 2, 3));
    issue(enc(2'd1, 2, 1, 4));
    issue(enc(2'd3, 3, 2, 1));
    @(negedge clk);
    rst = 1'b1; inst_valid = 1'b0; wb_ready = 1'b1;
    exp_q.delete();
    for (int r = 0; r < 32; r++) model_rf[r] = '0;
    @(negedge clk);
    #1;
    chk("flush_wb_valid", 32'(wb_valid), 32'd0);
    chk("flush_inst_ready", 32'(inst_ready), 32'd1);
    chk("flush_wb_addr", 32'(wb_addr), 32'd0);
    chk("flush_wb_data", wb_data, 32'd0);
    rst = 1'b0;
    check_rf("flush_rf");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
